trigger_capture: RTL and testbench

- Downstream of the threshold trigger stage. Consumes that stage's registered sample stream and its level trigger.
- Records a pre-/post-trigger window of ADC samples into an on-chip circular buffer.
- Exposes the captured window through a synchronous read port for the PS-side register bridge.
- Implements a single-shot arm → capture → done cycle.

---
 rtl/trigger_capture_pkg.sv | 25 ++
 rtl/capture_ram.sv | 27 ++
 rtl/trigger_capture.sv | 158 +++++++++++++++
 tb/tb_trigger_capture.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/trigger_capture_pkg.sv
// Shared types and default sizes for the trigger capture block.
// Imported by the controller top and its sample buffer.
package trigger_capture_pkg;

  localparam int unsigned DW_DEF  = 14;
  localparam int unsigned AW_DEF  = 10;
  localparam int unsigned DLY_DEF = 1;

  typedef enum logic [2:0] {
    IDLE,
    PRE_FILL,
    WAIT_TRIG,
    POST,
    DONE
  } cap_state_e;

  function automatic logic st_busy(
    input cap_state_e s
  );
    return (s == PRE_FILL) ||
           (s == WAIT_TRIG) ||
           (s == POST);
  endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample buffer, read-first registered read.
// No reset so that it maps onto block RAM.
module capture_ram #(
  parameter int unsigned DW = 14,
  parameter int unsigned AW = 10
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/trigger_capture.sv
// Single-shot pre/post-trigger window capture into a circular
// buffer, with a synchronous read port for the register bridge.
module trigger_capture
  import trigger_capture_pkg::*;
#(
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned DATA_DLY = DLY_DEF
) (
  input  logic          adc_clk,
  input  logic          adc_rstn,
  input  logic [DW-1:0] adc_dat,
  input  logic          trig_in,
  input  logic          arm,
  input  logic [AW-1:0] pre_len,
  input  logic [AW-1:0] post_len,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] trig_pos,
  output logic [AW-1:0] start_addr
);

  cap_state_e    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] pre_cnt_q, pre_cnt_d;
  logic [AW-1:0] post_cnt_q, post_cnt_d;
  logic [AW-1:0] pre_l_q, pre_l_d;
  logic [AW-1:0] post_l_q, post_l_d;
  logic [AW-1:0] trig_pos_q, trig_pos_d;
  logic [AW-1:0] start_q, start_d;
  logic          trig_prev_q;
  logic          rd_valid_q;
  logic          rd_seen_q;
  logic [DW-1:0] dly_q [DATA_DLY];
  logic [DW-1:0] dly_dat;
  logic [DW-1:0] ram_rdata;
  logic [AW-1:0] room;
  logic          trig_edge;
  logic          wr_en;

  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn) begin
      for (int i = 0; i < DATA_DLY; i++) begin
        dly_q[i] <= '0;
      end
    end else begin
      dly_q[0] <= adc_dat;
      for (int i = 1; i < DATA_DLY; i++) begin
        dly_q[i] <= dly_q[i-1];
      end
    end
  end

  assign dly_dat   = dly_q[DATA_DLY-1];
  assign trig_edge = trig_in & ~trig_prev_q;
  assign wr_en     = st_busy(state_q);
  // ~pre_len == 2^AW-1-pre_len: keeps the window within depth
  assign room      = ~pre_len;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    pre_cnt_d  = pre_cnt_q;
    post_cnt_d = post_cnt_q;
    pre_l_d    = pre_l_q;
    post_l_d   = post_l_q;
    trig_pos_d = trig_pos_q;
    start_d    = start_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (arm) begin
      pre_l_d    = pre_len;
      post_l_d   = (post_len > room) ? room : post_len;
      pre_cnt_d  = '0;
      post_cnt_d = '0;
      state_d    = (pre_len == '0) ? WAIT_TRIG : PRE_FILL;
    end else begin
      unique case (state_q)
        PRE_FILL: begin
          pre_cnt_d = pre_cnt_q + AW'(1);
          if (pre_cnt_q == pre_l_q - AW'(1)) begin
            state_d = WAIT_TRIG;
          end
        end
        WAIT_TRIG: begin
          if (trig_edge) begin
            trig_pos_d = wr_ptr_q;
            start_d    = wr_ptr_q - pre_l_q;
            post_cnt_d = '0;
            state_d    = (post_l_q == '0) ? DONE : POST;
          end
        end
        POST: begin
          post_cnt_d = post_cnt_q + AW'(1);
          if (post_cnt_q == post_l_q - AW'(1)) begin
            state_d = DONE;
          end
        end
        IDLE, DONE: ;
      endcase
    end
  end

  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
      pre_l_q     <= '0;
      post_l_q    <= '0;
      trig_pos_q  <= '0;
      start_q     <= '0;
      trig_prev_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_seen_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      pre_cnt_q   <= pre_cnt_d;
      post_cnt_q  <= post_cnt_d;
      pre_l_q     <= pre_l_d;
      post_l_q    <= post_l_d;
      trig_pos_q  <= trig_pos_d;
      start_q     <= start_d;
      trig_prev_q <= trig_in;
      rd_valid_q  <= rd_en;
      rd_seen_q   <= rd_seen_q | rd_en;
    end
  end

  capture_ram #(
    .DW (DW),
    .AW (AW)
  ) u_ram (
    .clk_i   (adc_clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (dly_dat),
    .re_i    (rd_en),
    .raddr_i (rd_addr),
    .rdata_o (ram_rdata)
  );

  // RAM output is unreset; mask it until the first read lands
  assign rd_data    = rd_seen_q ? ram_rdata : '0;
  assign rd_valid   = rd_valid_q;
  assign busy       = st_busy(state_q);
  assign done       = (state_q == DONE);
  assign trig_pos   = trig_pos_q;
  assign start_addr = start_q;

endmodule

// File: tb/tb_trigger_capture.sv
// Randomized bench for trigger_capture: sample history kept by
// index, expected window derived from arm/trigger sample indices.
module tb_trigger_capture;

  localparam int DW = 14;
  localparam int AW = 10;

  logic          adc_clk  = 1'b0;
  logic          adc_rstn = 1'b0;
  logic [DW-1:0] adc_dat  = '0;
  logic          trig_in  = 1'b0;
  logic          arm      = 1'b0;
  logic [AW-1:0] pre_len  = '0;
  logic [AW-1:0] post_len = '0;
  logic          rd_en    = 1'b0;
  logic [AW-1:0] rd_addr  = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          busy;
  logic          done;
  logic [AW-1:0] trig_pos;
  logic [AW-1:0] start_addr;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int a_q, pre_m, postl_m;
  logic [DW-1:0] smp [int];

  always #5 adc_clk = ~adc_clk;

  trigger_capture dut (
    .adc_clk    (adc_clk),
    .adc_rstn   (adc_rstn),
    .adc_dat    (adc_dat),
    .trig_in    (trig_in),
    .arm        (arm),
    .pre_len    (pre_len),
    .post_len   (post_len),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .busy       (busy),
    .done       (done),
    .trig_pos   (trig_pos),
    .start_addr (start_addr)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // sample index cyc is presented on adc_dat until the next edge
  task automatic tick();
    @(posedge adc_clk);
    #1;
    cyc++;
    adc_dat  = DW'($urandom);
    smp[cyc] = adc_dat;
  endtask

  task automatic do_arm(input int pre, input int post);
    arm      = 1'b1;
    pre_len  = AW'(pre);
    post_len = AW'(post);
    a_q      = cyc;
    pre_m    = pre;
    postl_m  = (post > 1023 - pre) ? 1023 - pre : post;
    tick();
    arm = 1'b0;
  endtask

  task automatic rd(
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] d,
    output logic          v
  );
    rd_en   = 1'b1;
    rd_addr = addr;
    tick();
    d     = rd_data;
    v     = rd_valid;
    rd_en = 1'b0;
  endtask

  task automatic check_window(input int x);
    logic [DW-1:0] d, last;
    logic          v;
    logic [AW-1:0] tp, st, e;
    tp = trig_pos;
    st = start_addr;
    e  = tp - AW'(pre_m);
    check("start_addr", 32'(st), 32'(e));
    rd(tp, d, v);
    check("trig_valid", 32'(v), 1);
    check("trig_sample", 32'(d), 32'(smp[x]));
    last = d;
    for (int i = 0; i <= pre_m + postl_m; i++) begin
      rd(st + AW'(i), d, v);
      check("win", 32'(d), 32'(smp[x - pre_m + i]));
      last = smp[x - pre_m + i];
    end
    tick();
    check("rd_valid_drop", 32'(rd_valid), 0);
    check("rd_data_hold", 32'(rd_data), 32'(last));
  endtask

  // drive trig for a pulse at sample p and a level edge at sample x
  task automatic finish(input int x, input int p);
    trig_in = (cyc == p + 1) || (cyc >= x + 1);
    while (cyc < x + postl_m + 1) begin
      tick();
      trig_in = (cyc == p + 1) || (cyc >= x + 1);
    end
    check("busy_last_post", 32'(busy), 1);
    check("done_early", 32'(done), 0);
    tick();
    check("done_rise", 32'(done), 1);
    check("busy_fall", 32'(busy), 0);
    trig_in = 1'b0;
    check_window(x);
  endtask

  task automatic run_capture(
    input int pre, input int post,
    input int toff, input int poff
  );
    trig_in = 1'b0;
    do_arm(pre, post);
    finish(a_q + toff, (poff >= 0) ? a_q + poff : -10);
  endtask

  initial begin
    int x, pre, post, toff, poff;
    logic bad;
    smp[0] = adc_dat;
    #2;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_trig_pos", 32'(trig_pos), 0);
    check("rst_start", 32'(start_addr), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    tick();
    tick();
    adc_rstn = 1'b1;
    tick();

    run_capture(4, 3, 20, -1);
    run_capture(8, 5, 12, 3);

    // level trigger held across arm must not fire
    trig_in = 1'b1;
    tick();
    tick();
    do_arm(0, 4);
    while (cyc < a_q + 10) tick();
    check("held_busy", 32'(busy), 1);
    check("held_done", 32'(done), 0);
    trig_in = 1'b0;
    finish(a_q + 30, -10);

    run_capture(1000, 100, 2000, -1);
    run_capture(0, 0, 5, -1);

    // re-arm in POST restarts the capture
    trig_in = 1'b0;
    do_arm(3, 10);
    x = a_q + 8;
    while (cyc < x + 4) begin
      tick();
      trig_in = (cyc >= x + 1);
    end
    check("rearm_busy", 32'(busy), 1);
    check("rearm_done", 32'(done), 0);
    trig_in = 1'b0;
    do_arm(2, 2);
    finish(a_q + 6, -10);

    // reset during POST
    trig_in = 1'b0;
    do_arm(2, 20);
    x = a_q + 5;
    while (cyc < x + 5) begin
      tick();
      trig_in = (cyc >= x + 1);
    end
    check("mid_busy", 32'(busy), 1);
    adc_rstn = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_done", 32'(done), 0);
    check("arst_trig_pos", 32'(trig_pos), 0);
    check("arst_start", 32'(start_addr), 0);
    tick();
    adc_rstn = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      trig_in = 1'($urandom);
      tick();
      bad = bad | busy | done;
    end
    check("idle_after_rst", 32'(bad), 0);

    for (int k = 0; k < 8; k++) begin
      if (k == 7) begin
        pre  = $urandom_range(1000, 1023);
        post = $urandom_range(0, 200);
      end else begin
        pre  = $urandom_range(0, 40);
        post = $urandom_range(0, 40);
      end
      toff = pre + int'($urandom_range(0, 30));
      poff = -1;
      if (pre >= 2 && $urandom_range(0, 1) == 1) begin
        poff = $urandom_range(0, pre - 2);
      end
      run_capture(pre, post, toff, poff);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
